// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults and helpers for the tick_gen divider bank.
package tick_gen_pkg;

    // Default channel counter/divisor width.
    localparam int TG_WIDTH_DEF  = 25;
    // Default number of independent divider channels.
    localparam int TG_NUM_CH_DEF = 4;

    // Width of the channel-select field; never narrower than one bit so a
    // single-channel build still has a usable Div_Sel port.
    function automatic int tg_sel_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one divider channel (divisor, counter, registered tick and
// optional square-wave toggle). The toggle flop exists only when
// TICK_GEN_TOGGLE_EN is defined; otherwise Toggle_o is tied low.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int               WIDTH   = TG_WIDTH_DEF,
    parameter logic [WIDTH-1:0] DIV_RST = '1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Sync_Clr_i,
    input  logic             En_i,
    input  logic             Wr_i,
    input  logic [WIDTH-1:0] Div_Val_i,
    output logic             Tick_o,
    output logic             Toggle_o
);

    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             at_term;

    // Terminal count; a counter above the divisor simply keeps counting and
    // wraps through all ones, so it only ticks once it comes back to D.
    assign at_term = (cnt_q == div_q);

    // Next-state: write and phase-align both zero the counter and kill the tick;
    // otherwise an enabled channel counts modulo D+1.
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (Wr_i) begin
            div_d = Div_Val_i;
        end
        if (Wr_i || Sync_Clr_i) begin
            cnt_d = '0;
        end else if (En_i) begin
            cnt_d  = at_term ? '0 : cnt_q + WIDTH'(1);
            tick_d = at_term;
        end
    end

    // Channel state registers; reset wins over every other request.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_q  <= DIV_RST;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign Tick_o = tick_q;

`ifdef TICK_GEN_TOGGLE_EN
    logic tog_q;

    // Square wave: flips on the same edge that raises Tick, giving 50% duty.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tog_q <= 1'b0;
        end else if (tick_d) begin
            tog_q <= ~tog_q;
        end
    end

    assign Toggle_o = tog_q;
`else
    assign Toggle_o = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// tick_gen: bank of NUM_CH programmable tick dividers. Top level decodes the
// divisor write and fans common controls out to the per-channel instances.
// Optional macro TICK_GEN_TOGGLE_EN enables the per-channel Toggle output.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int               WIDTH   = TG_WIDTH_DEF,
    parameter int               NUM_CH  = TG_NUM_CH_DEF,
    parameter logic [WIDTH-1:0] DIV_RST = '1,
    localparam int              SEL_W   = tg_sel_w(NUM_CH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Sync_Clr,
    input  logic [NUM_CH-1:0] En,
    input  logic              Div_Wr,
    input  logic [SEL_W-1:0]  Div_Sel,
    input  logic [WIDTH-1:0]  Div_Val,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Toggle
);

    logic [NUM_CH-1:0] wr_sel;

    // One-hot write decode; selects at or above NUM_CH match no channel and
    // are therefore dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Div_Wr && (Div_Sel == SEL_W'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_gen_ch #(
            .WIDTH   (WIDTH),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .Clk        (Clk),
            .Rst        (Rst),
            .Sync_Clr_i (Sync_Clr),
            .En_i       (En[g]),
            .Wr_i       (wr_sel[g]),
            .Div_Val_i  (Div_Val),
            .Tick_o     (Tick[g]),
            .Toggle_o   (Toggle[g])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed scenarios for tick_gen. Stimulus pushes hand-computed
// expected Tick/Toggle values tagged with the cycle they must appear in; a
// monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_tick_gen;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 3;
    localparam int SEL_W  = 2;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Sync_Clr;
    logic [NUM_CH-1:0] En;
    logic              Div_Wr;
    logic [SEL_W-1:0]  Div_Sel;
    logic [WIDTH-1:0]  Div_Val;
    logic [NUM_CH-1:0] Tick;
    logic [NUM_CH-1:0] Toggle;

    tick_gen #(
        .WIDTH   (WIDTH),
        .NUM_CH  (NUM_CH),
        .DIV_RST (8'hFF)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Sync_Clr (Sync_Clr),
        .En       (En),
        .Div_Wr   (Div_Wr),
        .Div_Sel  (Div_Sel),
        .Div_Val  (Div_Val),
        .Tick     (Tick),
        .Toggle   (Toggle)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] mask;
        logic [NUM_CH-1:0] tick;
        bit                chk_tog;
        logic [NUM_CH-1:0] tog;
        string             name;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Expected value for the output seen after edge (current edge count + off).
    task automatic push(input string name, input int off, input logic [NUM_CH-1:0] mask,
                        input logic [NUM_CH-1:0] tick, input bit chk_tog,
                        input logic [NUM_CH-1:0] tog);
        exp_t e;
        e.cyc = cyc + off;
        e.mask = mask;
        e.tick = tick;
        e.chk_tog = chk_tog;
        e.tog = tog;
`ifndef TICK_GEN_TOGGLE_EN
        e.chk_tog = 1'b1;
        e.tog = '0;
`endif
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        Rst = 1'b1; Div_Wr = 1'b0; Sync_Clr = 1'b0; En = '0;
        push("rst_mid", 2, '1, '0, 1'b1, '0);
        step(2);
        Rst = 1'b0;
    endtask

    // Monitor: sample 1ns after each rising edge, check every entry due now.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            cyc++;
            #1;
            for (int k = sbq.size() - 1; k >= 0; k--) begin
                if (sbq[k].cyc == cyc) begin
                    e = sbq[k];
                    sbq.delete(k);
                    n_chk++;
                    if ((Tick & e.mask) !== (e.tick & e.mask)) begin
                        n_fail++;
                        $display("FAIL %s tick @cyc %0d: got %b want %b (mask %b)",
                                 e.name, cyc, Tick & e.mask, e.tick & e.mask, e.mask);
                    end
                    if (e.chk_tog) begin
                        n_chk++;
                        if ((Toggle & e.mask) !== (e.tog & e.mask)) begin
                            n_fail++;
                            $display("FAIL %s toggle @cyc %0d: got %b want %b (mask %b)",
                                     e.name, cyc, Toggle & e.mask, e.tog & e.mask, e.mask);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [NUM_CH-1:0] tv, gv;

        // Reset with write, clear and enable all active: reset must win.
        Rst = 1'b1; Div_Wr = 1'b1; Div_Sel = '0; Div_Val = 8'd3;
        Sync_Clr = 1'b1; En = '1;
        for (int o = 1; o <= 3; o++) push("rst_prio", o, '1, '0, 1'b1, '0);
        step(3);

        // First tick after reset comes from the reset divisor (255), not the
        // value that was on Div_Val during reset.
        Rst = 1'b0; Div_Wr = 1'b0; Sync_Clr = 1'b0; En = 3'b001;
        push("rst_div_pre",  255, 3'b001, 3'b000, 1'b1, 3'b000);
        push("rst_div_tick", 256, 3'b001, 3'b001, 1'b1, 3'b001);
        push("rst_div_post", 257, 3'b001, 3'b000, 1'b1, 3'b001);
        step(257);
        do_reset();

        // D=3 on ch0: tick every 4 cycles, toggle period 8.
        Div_Wr = 1'b1; Div_Sel = 2'd0; Div_Val = 8'd3; En = 3'b001;
        for (int o = 1; o <= 17; o++) begin
            tv = '0; gv = '0;
            tv[0] = (o >= 5) && ((o - 5) % 4 == 0);
            gv[0] = ((o - 1) / 4) % 2 == 1;
            push("d3_ch0", o, 3'b001, tv, 1'b1, gv);
        end
        step(1); Div_Wr = 1'b0;
        step(16);
        do_reset();

        // D=0 on ch1: tick held high, toggle every cycle; others stay idle.
        Div_Wr = 1'b1; Div_Sel = 2'd1; Div_Val = 8'd0; En = 3'b010;
        for (int o = 1; o <= 10; o++) begin
            tv = '0; gv = '0;
            tv[1] = (o >= 2);
            gv[1] = (o >= 2) && ((o - 1) % 2 == 1);
            push("d0_ch1", o, '1, tv, 1'b1, gv);
        end
        step(1); Div_Wr = 1'b0;
        step(9);
        // Disable: tick drops next cycle, toggle holds.
        En = 3'b000;
        push("d0_dis", 1, '1, 3'b000, 1'b1, 3'b010);
        step(2);
        do_reset();

        // Out-of-range select is ignored: all channels keep D=255, no ticks.
        Div_Wr = 1'b1; Div_Sel = 2'd3; Div_Val = 8'd0; En = 3'b111;
        for (int o = 1; o <= 6; o++) push("bad_sel", o, '1, 3'b000, 1'b0, '0);
        step(1); Div_Wr = 1'b0;
        step(5);
        do_reset();

        // ch0 D=9 counted to C=5, then rewritten to D=2.
        Div_Wr = 1'b1; Div_Sel = 2'd0; Div_Val = 8'd9; En = 3'b001;
        for (int o = 1; o <= 6; o++) push("d9_run", o, 3'b001, 3'b000, 1'b0, '0);
        step(1); Div_Wr = 1'b0;
        step(5);
        Div_Wr = 1'b1; Div_Val = 8'd2;
        for (int o = 1; o <= 10; o++) begin
            tv = '0;
            tv[0] = (o >= 4) && ((o - 4) % 3 == 0);
            push("rewr_d2", o, 3'b001, tv, 1'b0, '0);
        end
        step(1); Div_Wr = 1'b0;
        step(9);
        do_reset();

        // ch0 D=4, ch1 D=6 mid-count, then Sync_Clr on the edge ch0 would tick.
        Div_Wr = 1'b1; Div_Sel = 2'd0; Div_Val = 8'd4; En = 3'b011;
        step(1);
        Div_Sel = 2'd1; Div_Val = 8'd6;
        step(1);
        Div_Wr = 1'b0;
        step(3);
        Sync_Clr = 1'b1;
        for (int o = 1; o <= 16; o++) begin
            tv = '0;
            tv[0] = (o > 1) && ((o - 1) % 5 == 0);
            tv[1] = (o > 1) && ((o - 1) % 7 == 0);
            push("sync_clr", o, 3'b011, tv, 1'b0, '0);
        end
        step(1); Sync_Clr = 1'b0;
        step(15);
        // Write to ch2 (D=1) together with Sync_Clr: divisor loads, all clear.
        Div_Wr = 1'b1; Div_Sel = 2'd2; Div_Val = 8'd1; Sync_Clr = 1'b1; En = 3'b111;
        for (int o = 1; o <= 8; o++) begin
            tv = '0;
            tv[0] = (o == 6);
            tv[1] = (o == 8);
            tv[2] = (o >= 3) && (o % 2 == 1);
            push("sync_wr", o, '1, tv, 1'b0, '0);
        end
        step(1); Div_Wr = 1'b0; Sync_Clr = 1'b0;
        step(7);
        do_reset();

        // ch2 D=5: pause at C=2 for 10 cycles, resume from held count.
        Div_Wr = 1'b1; Div_Sel = 2'd2; Div_Val = 8'd5; En = 3'b100;
        for (int o = 1; o <= 3; o++) push("en_pre", o, 3'b100, 3'b000, 1'b0, '0);
        step(1); Div_Wr = 1'b0;
        step(2);
        En = 3'b000;
        for (int o = 1; o <= 10; o++) push("en_hold", o, 3'b100, 3'b000, 1'b0, '0);
        step(10);
        En = 3'b100;
        for (int o = 1; o <= 10; o++) begin
            tv = '0;
            tv[2] = (o == 4) || (o == 10);
            push("en_resume", o, 3'b100, tv, 1'b0, '0);
        end
        step(10);
        step(2);

        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending entries want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter WIDTH, 25, bit width of each channel's counter and divisor.
REQ-002 Parameter NUM_CH, 4, number of independent divider channels (1..16).
REQ-003 Parameter DIV_RST, all ones (WIDTH bits), divisor value loaded into every channel at reset.
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 Sync_Clr  input  1  one-cycle request to zero all channel counters (phase alignment).
REQ-007 En  input  NUM_CH  per-channel count enable.
REQ-008 Div_Wr  input  1  divisor write strobe.
REQ-009 Div_Sel  input  clog2(NUM_CH), min 1  channel addressed by Div_Wr.
REQ-010 Div_Val  input  WIDTH  divisor written on Div_Wr.
REQ-011 Tick  output  NUM_CH  registered one-cycle pulse per channel period.
REQ-012 Toggle  output  NUM_CH  registered square wave, flips on every Tick.

Function
REQ-013 Each channel SHALL hold a divisor register D and a counter C, both WIDTH bits.
REQ-014 En[i]=1: C SHALL go to 0 when C==D, else to C+1; Tick[i] SHALL be 1 in the cycle after C==D, so the period is D+1 cycles.
REQ-015 D=0 with En[i]=1 SHALL hold Tick[i] at 1 continuously.
REQ-016 En[i]=0: C SHALL hold its value and Tick[i] SHALL be 0 in the following cycle; resuming SHALL continue from the held C.
REQ-017 Div_Wr with Div_Sel=i SHALL load D[i]<=Div_Val and C[i]<=0 on the same edge; Tick[i] SHALL be 0 in the following cycle.
REQ-018 Div_Sel >= NUM_CH SHALL ignore the write.
REQ-019 Sync_Clr SHALL set every C to 0 and every Tick to 0 on the next edge; D and Toggle are unchanged.
REQ-020 Sync_Clr with Div_Wr in the same cycle: the divisor SHALL load and all counters SHALL clear.
REQ-021 Counter arithmetic SHALL be modulo 2^WIDTH; C > D (impossible except after a failed write) SHALL still wrap through all ones to 0, with no Tick until C==D.
REQ-022 Toggle[i] SHALL invert in the same cycle that Tick[i] is 1; period 2*(D+1) with 50% duty.

Reset
REQ-023 While Rst=1: every C=0, every D=DIV_RST, Tick=0, Toggle=0; Rst overrides Div_Wr, Sync_Clr and En.
REQ-024 The first Tick after Rst deasserts with En=1 SHALL occur DIV_RST+1 cycles after the first counting edge.

Configuration
REQ-025 Macro TICK_GEN_TOGGLE_EN defined: Toggle SHALL behave per REQ-022.
REQ-026 Macro TICK_GEN_TOGGLE_EN undefined: Toggle SHALL be tied to 0, no toggle flops are synthesised, and the port list is unchanged.

Structure
REQ-027 Package tick_gen_pkg SHALL hold the default WIDTH, the default NUM_CH and the channel-select width function.
REQ-028 Sub-module tick_gen_ch SHALL implement one channel (D, C, Tick, Toggle) and SHALL be instantiated NUM_CH times in a generate loop; the top level holds only address decode.

Verification
REQ-029 Rst; write D=3 to ch0; En=1 -> Tick[0] pulses every 4 cycles, Toggle[0] period 8.
REQ-030 D=0 on ch1, En[1]=1 -> Tick[1] stays at 1; Toggle[1] toggles every cycle.
REQ-031 ch0 at D=9 with C=5; write D=2 -> next Tick 3 cycles after the write edge, then every 3 cycles.
REQ-032 ch0 D=4, ch1 D=6, mid-count; pulse Sync_Clr -> both counters restart from 0 on the same edge; Tick at LCM-aligned points (ch0 every 5 cycles, ch1 every 7).
REQ-033 En[2] dropped at C=2 for 10 cycles, then restored, D=5 -> Tick[2] arrives 4 counting cycles after restore; no Tick while disabled.
REQ-034 Assert Rst with Div_Wr and Sync_Clr active -> all D=DIV_RST, C=0, Tick=0, Toggle=0; with TICK_GEN_TOGGLE_EN undefined, Toggle stays 0 throughout all scenarios.
